// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU/LSU results onto the regfile write port and tracks pending rd.
// Optional macro RF_WB_BYPASS_EN enables same-cycle forwarding of wr_data to scoreboard queries.
module regfile_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   chk_addr_1,
  output logic            chk_busy_1,
  input  logic [AW-1:0]   chk_addr_2,
  output logic            chk_busy_2,
  output logic            fwd_hit_1,
  output logic            fwd_hit_2
);

  localparam int NREG = 1 << AW;

  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0] sb_q, sb_d;
  logic            raw_busy_1, raw_busy_2;

  assign lsu_ready = 1'b1;
  assign alu_ready = ~lsu_valid;

  // Next-state: LSU wins the write port; scoreboard clears on write, set on issue (set wins).
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (lsu_valid) begin
      wr_en_d   = (lsu_rd != {AW{1'b0}});
      wr_addr_d = lsu_rd;
      wr_data_d = lsu_data;
    end else if (alu_valid) begin
      wr_en_d   = (alu_rd != {AW{1'b0}});
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end else begin
      wr_en_d   = 1'b0;
    end

    sb_d = sb_q;
    if (wr_en_q) begin
      sb_d[wr_addr_q] = 1'b0;
    end else begin
      sb_d = sb_q;
    end
    if (iss_valid && (iss_rd != {AW{1'b0}})) begin
      sb_d[iss_rd] = 1'b1;
    end else begin
      sb_d[0] = 1'b0;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_data_q <= {XLEN{1'b0}};
      sb_q      <= {NREG{1'b0}};
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sb_q      <= sb_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  assign raw_busy_1 = (chk_addr_1 != {AW{1'b0}}) && sb_q[chk_addr_1];
  assign raw_busy_2 = (chk_addr_2 != {AW{1'b0}}) && sb_q[chk_addr_2];

`ifdef RF_WB_BYPASS_EN
  // A write in flight to the queried register satisfies the consumer through wr_data.
  assign fwd_hit_1  = wr_en_q && (wr_addr_q == chk_addr_1) && (chk_addr_1 != {AW{1'b0}});
  assign fwd_hit_2  = wr_en_q && (wr_addr_q == chk_addr_2) && (chk_addr_2 != {AW{1'b0}});
  assign chk_busy_1 = raw_busy_1 && !fwd_hit_1;
  assign chk_busy_2 = raw_busy_2 && !fwd_hit_2;
`else
  assign fwd_hit_1  = 1'b0;
  assign fwd_hit_2  = 1'b0;
  assign chk_busy_1 = raw_busy_1;
  assign chk_busy_2 = raw_busy_2;
`endif

endmodule
